memory_unfold_collector: RTL and testbench

- Receive-side counterpart of the memory-folding processor. It collects a serial stream of MW words into one shared memory block, then runs an in-place pass that decrements every element (the inverse of the folding block's increment).
- It then replays the frame on a valid/ready output stream.
- Sits downstream of the folding block's sequential output and restores the original frame values for the consumer.

---
 rtl/memfold_pkg.sv | 14 +
 rtl/memory_unfold_collector.sv | 91 +++++++++
 tb/tb_memory_unfold_collector.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memfold_pkg.sv
// Shared definitions for the memory fold/unfold pair.
// The fold and unfold blocks use the same frame geometry and state encoding.
package memfold_pkg;

    localparam int BW_DEF = 8;
    localparam int MW_DEF = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PROC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/memory_unfold_collector.sv
// Collects a frame of MW words, decrements every element in place,
// then replays the frame in order on a valid/ready stream.
module memory_unfold_collector
    import memfold_pkg::*;
#(
    parameter int BW = BW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [BW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          frame_done
);

    localparam int AW = $clog2(MW);
    localparam logic [AW-1:0] LAST = AW'(MW - 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [BW-1:0] mem [MW];
    // Set once word MW-1 is loaded into out_data; ptr then stays at MW-1
    // instead of stepping past the end of the array.
    logic          last_out;

    assign in_ready = (state == FILL);
    assign busy     = (state != FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            last_out   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid) begin
                        mem[ptr] <= in_data;
                        if (ptr == LAST) begin
                            ptr   <= '0;
                            state <= PROC;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                PROC: begin
                    mem[ptr] <= mem[ptr] - BW'(1);
                    if (ptr == LAST) begin
                        // mem[0] was decremented on the first PROC cycle
                        out_data  <= mem[0];
                        out_valid <= 1'b1;
                        ptr       <= AW'(1);
                        last_out  <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_out) begin
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            ptr        <= '0;
                            last_out   <= 1'b0;
                            state      <= FILL;
                        end else begin
                            out_data <= mem[ptr];
                            if (ptr == LAST)
                                last_out <= 1'b1;
                            else
                                ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unfold_collector.sv
// Self-checking bench: table-driven first frame plus scripted corner cases,
// with a scoreboard queue filled on input accepts and drained on output transfers.
module tb_memory_unfold_collector;

    localparam int BW = 8;
    localparam int MW = 16;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    memory_unfold_collector #(.BW(BW), .MW(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;
    int fd_cnt = 0;
    int last_acc = 0;
    int first_ov = 0;
    logic prev_ov = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] got [$];

    logic [7:0] e1 [MW] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                            8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    vec_t vec [MW];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: everything seen at negedge completes on the following posedge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data - 8'd1);
                last_acc = cyc + 1;
            end
            if (out_valid && !prev_ov) first_ov = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                xfers++;
                got.push_back(out_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%0h with no word expected", out_data);
                end else begin
                    chk("sb_data", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gappy, input bit chk_ready);
        for (int i = 0; i < MW; i++) begin
            int n = 0;
            while (!in_ready && n < 500) begin
                tick();
                n++;
            end
            if (n >= 500) chk("send_timeout", 0, 1);
            if (chk_ready) chk("in_ready_fill", int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
            if (gappy && i < MW - 1) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_done_timeout"}, int'(n < 300), 1);
    endtask

    task automatic wait_xfers(input int target, input string name);
        int n = 0;
        while (xfers < target && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_xfer_timeout"}, int'(n < 300), 1);
    endtask

    initial begin
        int x0;
        int g0;
        int fd0;
        logic [7:0] held;

        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0;
        int g0;
        int fd0;
        logic [7:0] held;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid",  int'(out_valid), 0);
        chk("rst_out_data",   int'(out_data), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_in_ready",   int'(in_ready), 1);
        rst = 1'b0;
        tick();

        // Frame 1: table of inputs and expected outputs
        for (int i = 0; i < MW; i++) begin
            vec[i].din = 8'(i);
            vec[i].exp = e1[i];
        end
        x0 = xfers; g0 = got.size(); fd0 = fd_cnt;
        for (int i = 0; i < MW; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i].din;
            tick();
        end
        in_valid = 1'b0;
        wait_done("t1");
        tick();
        chk("t1_pulse_width", int'(frame_done), 0);
        chk("t1_fd_count", fd_cnt - fd0, 1);
        chk("t1_xfers", xfers - x0, MW);
        chk("t1_latency", first_ov - last_acc, MW);
        for (int i = 0; i < MW; i++)
            if (g0 + i < got.size()) chk("t1_table", int'(got[g0 + i]), int'(vec[i].exp));
            else chk("t1_table_missing", 0, 1);

        // Frame 2: gappy input
        x0 = xfers; g0 = got.size();
        send_frame(8'h10, 1'b1, 1'b1);
        chk("t2_in_ready_drop", int'(in_ready), 0);
        chk("t2_busy", int'(busy), 1);
        wait_done("t2");
        tick();
        chk("t2_xfers", xfers - x0, MW);
        chk("t2_first", int'(got[g0]), 8'h0F);
        chk("t2_last", int'(got[g0 + MW - 1]), 8'h1E);

        // Frame 3: back-pressure on the third word
        x0 = xfers;
        send_frame(8'h30, 1'b0, 1'b0);
        wait_xfers(x0 + 2, "t3");
        out_ready = 1'b0;
        held = out_data;
        chk("t3_third_word", int'(held), 8'h31);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_valid", int'(out_valid), 1);
            chk("t3_hold_data", int'(out_data), 8'h31);
        end
        out_ready = 1'b1;
        wait_done("t3");
        tick();
        chk("t3_xfers", xfers - x0, MW);

        // Frame 4: junk input while busy
        x0 = xfers;
        send_frame(8'h40, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int n = 0; n < 300 && xfers < x0 + MW - 1; n++) begin
            chk("t4_in_ready_low", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        wait_done("t4");
        tick();
        chk("t4_xfers", xfers - x0, MW);

        // Frame 5: reset mid-drain, then a fresh frame
        x0 = xfers;
        send_frame(8'h50, 1'b0, 1'b0);
        wait_xfers(x0 + 7, "t5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_in_ready", int'(in_ready), 1);
        x0 = xfers; g0 = got.size();
        send_frame(8'h80, 1'b0, 1'b0);
        wait_done("t5");
        tick();
        chk("t5_xfers", xfers - x0, MW);
        chk("t5_first", int'(got[g0]), 8'h7F);
        chk("t5_last", int'(got[g0 + MW - 1]), 8'h8E);

        // Frames 6/7: next frame starts in the frame_done cycle
        x0 = xfers; fd0 = fd_cnt;
        send_frame(8'h60, 1'b0, 1'b0);
        wait_done("t6a");
        chk("t6_in_ready_at_done", int'(in_ready), 1);
        send_frame(8'h70, 1'b0, 1'b0);
        chk("t6_latency_start", int'(out_valid), 0);
        wait_done("t6b");
        tick();
        chk("t6_latency", first_ov - last_acc, MW);
        chk("t6_xfers", xfers - x0, 2 * MW);
        chk("t6_fd_count", fd_cnt - fd0, 2);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
